// File: rtl/mul_iter_pkg.sv
// ============================================================================
// mul_iter_pkg : shared op and state encodings for the iterative multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_iter_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage : mul_iter_pkg

`default_nettype wire

// File: rtl/fulladder.sv
// ============================================================================
// fulladder : single-bit full adder cell
// Rev 1.0
// ============================================================================
`default_nettype none

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : fulladder

`default_nettype wire

// File: rtl/rca_adder.sv
// ============================================================================
// rca_adder : XLEN-bit ripple-carry adder built from a chain of fulladders
// Rev 1.0
// ============================================================================
`default_nettype none

module rca_adder #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            cout
);

  logic [XLEN:0] w_carry;

  assign w_carry[0] = cin;

  generate
    for (genvar i = 0; i < XLEN; i++) begin : g_fa
      fulladder u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (w_carry[i]),
        .sum  (sum[i]),
        .cout (w_carry[i+1])
      );
    end
  endgenerate

  assign cout = w_carry[XLEN];

endmodule : rca_adder

`default_nettype wire

// File: rtl/mul_iter.sv
// ============================================================================
// mul_iter : iterative shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU),
//            one partial product per clock, sign fix-up in a final cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_s1, w_s2;
  logic [XLEN-1:0]   w_add_b;
  logic [XLEN-1:0]   w_sum;
  logic              w_cout;
  logic [2*XLEN-1:0] w_acc;
  logic [2*XLEN-1:0] w_prod;

  // Only the signed-operand forms look at the sign bits.
  assign w_s1 = rs1[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU));
  assign w_s2 = rs2[XLEN-1] & (op == OP_MULH);

  assign w_add_b = lo_q[0] ? mcand_q : '0;

  rca_adder #(
    .XLEN (XLEN)
  ) u_adder (
    .a    (hi_q),
    .b    (w_add_b),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_acc  = {hi_q, lo_q};
  assign w_prod = neg_q ? (~w_acc + (2*XLEN)'(1)) : w_acc;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          neg_d   = w_s1 ^ w_s2;
          mcand_d = w_s1 ? (~rs1 + XLEN'(1)) : rs1;
          hi_d    = '0;
          lo_d    = w_s2 ? (~rs2 + XLEN'(1)) : rs2;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Adder carry-out becomes the new top bit as the pair shifts right.
        {hi_d, lo_d} = {w_cout, w_sum, lo_q[XLEN-1:1]};
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = (op_q == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule : mul_iter

`default_nettype wire

// File: tb/tb_mul_iter.sv
// ============================================================================
// tb_mul_iter : self-checking bench for mul_iter (directed table, random
//               vectors against an arithmetic model, multi-cycle corner cases)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_iter;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  mul_iter #(
    .XLEN (XLEN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  // Full-width signed product of the operands as the op interprets them.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (o == 2'b01 || o == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    sb = (o == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = sa * sb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one multiply and checks latency, busy window, result and done width.
  // inject > 0 pulses a second start with other operands at that CALC cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int inject);
    int n;
    logic busy_ok;
    @(posedge clk); #1;
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    busy_ok = (busy === 1'b1) && (done === 1'b0);
    n = 0;
    while (n < LAT + 8) begin
      @(posedge clk); #1;
      n++;
      if (n == inject) begin
        start = 1'b1; op = ~o; rs1 = ~a; rs2 = b ^ 32'h5A5A_A5A5;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({name, " latency"}, 32'(n), 32'(LAT));
    chk({name, " busy_window"}, {31'b0, busy_ok}, 32'd1);
    chk({name, " busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({name, " result"}, result, exp);
    @(posedge clk); #1;
    chk({name, " done_fall"}, {31'b0, done}, 32'd0);
    chk({name, " result_hold"}, result, exp);
  endtask

  vec_t tbl[8];

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int sel;

    tbl[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones"};
    tbl[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones"};
    tbl[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minneg"};
    tbl[3] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_minneg"};
    tbl[4] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_mixed"};
    tbl[5] = '{2'b01, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, "mulh_zero"};
    tbl[6] = '{2'b10, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, "mulhsu_neg3"};
    tbl[7] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_latency"};

    start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 0);
    end

    for (int i = 0; i < 60; i++) begin
      ro  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      ra  = $urandom();
      rb  = $urandom();
      if (sel == 1) begin
        ra = 32'($urandom_range(0, 15));
        rb = rb | 32'h8000_0000;
      end else if (sel == 2) begin
        ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0001;
      end
      run_op($sformatf("rand%0d", i), ro, ra, rb, ref_mul(ro, ra, rb), 0);
    end

    run_op("start_while_busy", 2'b00, 32'h0000_1234, 32'h0000_0100,
           32'h0012_3400, 5);

    // Abort mid-CALC; outputs must clear on the falling reset, not at a clock.
    @(posedge clk); #1;
    op = 2'b01; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_done", {31'b0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 2'b00, 32'd3, 32'd4, 32'h0000_000C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mul_iter

`default_nettype wire
